// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - port-address map shared by the I/O hub and its bench
package io_port_pkg;

    // Read-side ports
    localparam logic [7:0] PORT_SWITCHES   = 8'h20;
    localparam logic [7:0] PORT_BUTTONS    = 8'h24;
    localparam logic [7:0] PORT_IRQ_STATUS = 8'h25;

    // Read/write ports
    localparam logic [7:0] PORT_LEDS       = 8'h40;
    localparam logic [7:0] PORT_SSEG       = 8'h81;
    localparam logic [7:0] PORT_IRQ_MASK   = 8'h42;

    // Write-only port, write-1-to-clear of pending bits
    localparam logic [7:0] PORT_IRQ_ACK    = 8'h43;

    // Debounce counter width; DEBOUNCE_CYCLES must stay below 2**DBNC_CNT_W
    localparam int DBNC_CNT_W = 20;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-button 2-flop synchronizer plus optional debounce counter
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   btn_in      - raw asynchronous button level
//   btn_out     - accepted (synchronized, optionally debounced) level
// Build option IO_PORT_HUB_DEBOUNCE_EN: when defined, btn_out changes only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement; otherwise btn_out is the
// synchronized level directly.
module btn_debounce
    import io_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

`ifdef IO_PORT_HUB_DEBOUNCE_EN
    logic [DBNC_CNT_W-1:0] cnt_q, cnt_d;
    logic                  acc_q, acc_d;

    // Any cycle of agreement restarts the count, so only an unbroken run of
    // DEBOUNCE_CYCLES differing cycles moves the accepted value.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == DBNC_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign btn_out = acc_q;
`else
    // Count length is meaningless without the counter; keep the parameter referenced.
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = (DEBOUNCE_CYCLES > 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign btn_out = sync2_q;
`endif

endmodule

// File: rtl/io_port_hub.sv
// rtl/io_port_hub.sv - port-mapped I/O responder: output registers, read mux, button interrupts
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   port_id, out_port   - CPU port address and write data
//   io_strb             - one-cycle write strobe
//   in_port             - combinational read data for port_id
//   interrupt           - level IRQ, |(pending & mask)
//   switches, buttons   - asynchronous board inputs
//   leds, sseg_val      - output registers
// Build option IO_PORT_HUB_DEBOUNCE_EN enables the per-button debounce counter.
module io_port_hub
    import io_port_pkg::*;
#(
    parameter int SW_WIDTH        = 8,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 io_strb,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic [SW_WIDTH-1:0]  switches,
    input  logic [BTN_WIDTH-1:0] buttons,
    output logic [7:0]           leds,
    output logic [7:0]           sseg_val
);

    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s1_d;
    logic [SW_WIDTH-1:0]  sw_s2_q, sw_s2_d;
    logic [BTN_WIDTH-1:0] btn_acc;
    logic [BTN_WIDTH-1:0] btn_prev_q, btn_prev_d;
    logic [BTN_WIDTH-1:0] pending_q, pending_d;
    logic [BTN_WIDTH-1:0] mask_q, mask_d;
    logic [7:0]           leds_q, leds_d;
    logic [7:0]           sseg_q, sseg_d;
    logic [BTN_WIDTH-1:0] ack_bits;
    logic [BTN_WIDTH-1:0] rise;
    logic [7:0]           rd_data;

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_dbnc (
            .clk    (clk),
            .reset  (reset),
            .btn_in (buttons[i]),
            .btn_out(btn_acc[i])
        );
    end

    always_comb begin
        sw_s1_d    = switches;
        sw_s2_d    = sw_s1_q;
        leds_d     = leds_q;
        sseg_d     = sseg_q;
        mask_d     = mask_q;
        ack_bits   = '0;
        if (io_strb) begin
            case (port_id)
                PORT_LEDS:     leds_d   = out_port;
                PORT_SSEG:     sseg_d   = out_port;
                PORT_IRQ_MASK: mask_d   = out_port[BTN_WIDTH-1:0];
                PORT_IRQ_ACK:  ack_bits = out_port[BTN_WIDTH-1:0];
                default: ;
            endcase
        end
        // Set has priority over a same-cycle acknowledge so no press is lost.
        rise       = btn_acc & ~btn_prev_q;
        pending_d  = (pending_q & ~ack_bits) | rise;
        btn_prev_d = btn_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            leds_q     <= '0;
            sseg_q     <= '0;
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            btn_prev_q <= btn_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            leds_q     <= leds_d;
            sseg_q     <= sseg_d;
        end
    end

    // Every read source is a reset-cleared register, so in_port is 0 during reset.
    always_comb begin
        rd_data = '0;
        case (port_id)
            PORT_SWITCHES:   rd_data[SW_WIDTH-1:0]  = sw_s2_q;
            PORT_BUTTONS:    rd_data[BTN_WIDTH-1:0] = btn_acc;
            PORT_IRQ_STATUS: rd_data[BTN_WIDTH-1:0] = pending_q;
            PORT_LEDS:       rd_data                = leds_q;
            PORT_SSEG:       rd_data                = sseg_q;
            PORT_IRQ_MASK:   rd_data[BTN_WIDTH-1:0] = mask_q;
            default: ;
        endcase
    end

    assign in_port   = rd_data;
    assign interrupt = |(pending_q & mask_q);
    assign leds      = leds_q;
    assign sseg_val  = sseg_q;

endmodule

// File: tb/tb_io_port_hub.sv
// tb/tb_io_port_hub.sv - scoreboard bench for io_port_hub with a behavioural reference model
module tb_io_port_hub;

    localparam int SW_W = 8;
    localparam int BTN_W = 4;
    localparam int DC = 8;
`ifdef IO_PORT_HUB_DEBOUNCE_EN
    localparam int PRESS_LAT = 3 + DC;
`else
    localparam int PRESS_LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       port_id;
    logic [7:0]       out_port;
    logic             io_strb;
    logic [7:0]       in_port;
    logic             interrupt;
    logic [SW_W-1:0]  switches;
    logic [BTN_W-1:0] buttons;
    logic [7:0]       leds;
    logic [7:0]       sseg_val;

    io_port_hub #(
        .SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .io_strb(io_strb), .in_port(in_port), .interrupt(interrupt),
        .switches(switches), .buttons(buttons), .leds(leds), .sseg_val(sseg_val)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp_in;
        logic [7:0] exp_leds;
        logic [7:0] exp_sseg;
        logic       exp_irq;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [7:0]       m_leds, m_sseg;
    logic [BTN_W-1:0] m_mask, m_pend, m_acc, m_prev;
    int               m_run[BTN_W];
    logic [7:0]       sw_hist[$];
    logic [BTN_W-1:0] btn_hist[$];

    logic             cur_rst;
    logic [7:0]       cur_sw;
    logic [BTN_W-1:0] cur_btn;

    // Value visible after the 2-flop synchronizer: the input sampled two edges ago.
    function automatic logic [7:0] m_sw_sync();
        return (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 8'h00;
    endfunction

    function automatic logic [BTN_W-1:0] m_btn_sync();
        return (btn_hist.size() >= 2) ? btn_hist[btn_hist.size()-2] : '0;
    endfunction

    function automatic logic [BTN_W-1:0] m_acc_vis();
`ifdef IO_PORT_HUB_DEBOUNCE_EN
        return m_acc;
`else
        return m_btn_sync();
`endif
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] pid);
        logic [7:0] r = 8'h00;
        case (pid)
            8'h20: r = m_sw_sync();
            8'h24: r[BTN_W-1:0] = m_acc_vis();
            8'h25: r[BTN_W-1:0] = m_pend;
            8'h40: r = m_leds;
            8'h81: r = m_sseg;
            8'h42: r[BTN_W-1:0] = m_mask;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_leds = 0; m_sseg = 0; m_mask = 0; m_pend = 0; m_acc = 0; m_prev = 0;
        for (int i = 0; i < BTN_W; i++) m_run[i] = 0;
        sw_hist.delete();
        btn_hist.delete();
    endtask

    // Advance the model across one active clock edge using the pre-edge inputs.
    task automatic model_edge();
        logic [BTN_W-1:0] s       = m_btn_sync();
        logic [BTN_W-1:0] av      = m_acc_vis();
        logic [BTN_W-1:0] new_acc = m_acc;
        logic [BTN_W-1:0] ack     = '0;
`ifdef IO_PORT_HUB_DEBOUNCE_EN
        for (int i = 0; i < BTN_W; i++) begin
            if (s[i] == m_acc[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == DC) begin
                new_acc[i] = s[i];
                m_run[i] = 0;
            end else m_run[i] = m_run[i] + 1;
        end
`else
        new_acc = s;
`endif
        if (io_strb) begin
            case (port_id)
                8'h40: m_leds = out_port;
                8'h81: m_sseg = out_port;
                8'h42: m_mask = out_port[BTN_W-1:0];
                8'h43: ack = out_port[BTN_W-1:0];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~ack) | (av & ~m_prev);
        m_prev = av;
        m_acc = new_acc;
        sw_hist.push_back(switches);
        btn_hist.push_back(buttons);
        if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        if (btn_hist.size() > 4) void'(btn_hist.pop_front());
    endtask

    // One bus cycle: cross an edge, present new inputs, queue the expected outputs.
    // ovr >= 0 pins the expected in_port to a fixed value instead of the model.
    task automatic step(input logic [7:0] pid, input logic [7:0] dat, input logic strb,
                        input string tag, input int ovr);
        exp_t e;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        reset = cur_rst;
        port_id = pid;
        out_port = dat;
        io_strb = strb;
        switches = cur_sw;
        buttons = cur_btn;
        if (cur_rst) model_reset();
        e.tag = tag;
        e.exp_in = (ovr >= 0) ? ovr[7:0] : m_read(pid);
        e.exp_leds = m_leds;
        e.exp_sseg = m_sseg;
        e.exp_irq = |(m_pend & m_mask);
        sbq.push_back(e);
    endtask

    task automatic check(input string tag, input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %02h expected %02h at %0t", tag, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check(e.tag, "in_port", in_port, e.exp_in);
            check(e.tag, "leds", leds, e.exp_leds);
            check(e.tag, "sseg_val", sseg_val, e.exp_sseg);
            check(e.tag, "interrupt", {7'd0, interrupt}, {7'd0, e.exp_irq});
        end
    end

    logic [7:0] ports[10] = '{8'h20, 8'h24, 8'h25, 8'h40, 8'h81, 8'h42, 8'h43, 8'h55, 8'h00, 8'hFF};

    initial begin
        reset = 1'b1; port_id = 0; out_port = 0; io_strb = 0; switches = 0; buttons = 0;
        cur_rst = 1'b1; cur_sw = 0; cur_btn = 0;
        model_reset();

        step(8'h25, 0, 0, "reset_0x25", 0);
        step(8'h40, 0, 0, "reset_0x40", 0);
        cur_rst = 1'b0;

        // Register writes and read-back
        step(8'h40, 8'hA5, 1, "wr_leds", -1);
        step(8'h81, 8'h3C, 1, "wr_sseg", -1);
        step(8'h40, 8'h00, 0, "rd_leds", 8'hA5);
        step(8'h55, 8'hFF, 1, "wr_unmapped", -1);
        step(8'h55, 8'h00, 0, "rd_unmapped", 0);
        step(8'h81, 8'h00, 0, "rd_sseg", 8'h3C);

        // Switch synchronizer latency
        cur_sw = 8'h5A;
        step(8'h20, 0, 0, "sw_edge0", 0);
        step(8'h20, 0, 0, "sw_edge1", 0);
        step(8'h20, 0, 0, "sw_edge2", 8'h5A);

        // Button 1 bouncing with 5-cycle pulses
        for (int k = 0; k < 3; k++) begin
            cur_btn = 4'b0010;
            repeat (5) step(8'h25, 0, 0, "bounce_hi", -1);
            cur_btn = 4'b0000;
            repeat (5) step(8'h25, 0, 0, "bounce_lo", -1);
        end
        repeat (12) step(8'h24, 0, 0, "bounce_settle", -1);
`ifdef IO_PORT_HUB_DEBOUNCE_EN
        step(8'h25, 0, 0, "bounce_no_pend", 0);
`else
        step(8'h25, 0, 0, "bounce_pend", 8'h02);
`endif

        // Held press is accepted; mask gates the interrupt
        cur_btn = 4'b0010;
        repeat (12) step(8'h25, 0, 0, "hold", -1);
        step(8'h25, 0, 0, "held_pend", 8'h02);
        step(8'h42, 8'h02, 1, "wr_mask", -1);
        step(8'h25, 0, 0, "irq_on", 8'h02);
        step(8'h42, 0, 0, "rd_mask", 8'h02);

        // Acknowledge clears pending and drops the interrupt
        step(8'h43, 8'h02, 1, "ack", -1);
        step(8'h25, 0, 0, "after_ack", 0);

        // Acknowledge on the same edge as a new rising edge: the set wins
        cur_btn = 4'b0000;
        repeat (14) step(8'h24, 0, 0, "release", -1);
        cur_btn = 4'b0010;
        step(8'h25, 0, 0, "race_press", 0);
        for (int i = 1; i <= PRESS_LAT - 2; i++) step(8'h25, 0, 0, "race_wait", 0);
        step(8'h43, 8'h02, 1, "race_ack", 0);
        step(8'h25, 0, 0, "race_set_wins", 8'h02);

        // Button 0 press latency
        step(8'h43, 8'h0F, 1, "ack_all", -1);
        cur_btn = 4'b0000;
        repeat (14) step(8'h24, 0, 0, "release2", -1);
        cur_btn = 4'b0001;
        step(8'h25, 0, 0, "b0_press", 0);
        for (int i = 1; i < PRESS_LAT; i++) step(8'h25, 0, 0, "b0_wait", 0);
        step(8'h25, 0, 0, "b0_pend", 8'h01);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] pid = ports[$urandom_range(9)];
            if ($urandom_range(7) == 0) cur_sw = 8'($urandom);
            if ($urandom_range(11) == 0) cur_btn = cur_btn ^ BTN_W'(1 << $urandom_range(BTN_W-1));
            step(pid, 8'($urandom), ($urandom_range(2) == 0), "random", -1);
            if (n == 200) begin
                step(8'h40, 8'hC3, 1, "pre_reset_wr", -1);
                step(8'h42, 8'h0F, 1, "pre_reset_mask", -1);
                cur_rst = 1'b1;
                step(8'h25, 0, 0, "midrun_reset_0x25", 0);
                step(8'h40, 0, 0, "midrun_reset_0x40", 0);
                cur_rst = 1'b0;
            end
        end

        begin
            int guard = 0;
            while (sbq.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (sbq.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sbq.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
